// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> load-use hazard unit signal bundle. The pipeline side (master) drives
// decode/EX/memory status and the hazard unit (slave) returns the stall controls.
interface hazard_scoreboard_if #(
    parameter int unsigned RAW     = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = 16
);
    logic [NUM_SRC-1:0]     id_src_valid;
    logic [NUM_SRC*RAW-1:0] id_src_addr;
    logic                   ex_valid;
    logic                   ex_mem_ren;
    logic [RAW-1:0]         ex_waddr;
    logic                   ld_issue;
    logic [RAW-1:0]         ld_issue_waddr;
    logic                   ld_resp;

    logic                       pc_enable;
    logic                       if_id_enable;
    logic                       id_ex_enable;
    logic                       hazard_clear_ctrl;
    logic [$clog2(DEPTH):0]     sb_count;
    logic [CNT_W-1:0]           stall_cycles;
    logic                       sb_err;

    modport master (
        output id_src_valid, id_src_addr, ex_valid, ex_mem_ren, ex_waddr,
               ld_issue, ld_issue_waddr, ld_resp,
        input  pc_enable, if_id_enable, id_ex_enable, hazard_clear_ctrl,
               sb_count, stall_cycles, sb_err
    );

    modport slave (
        input  id_src_valid, id_src_addr, ex_valid, ex_mem_ren, ex_waddr,
               ld_issue, ld_issue_waddr, ld_resp,
        output pc_enable, if_id_enable, id_ex_enable, hazard_clear_ctrl,
               sb_count, stall_cycles, sb_err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Load-use hazard unit: checks decode sources against the EX load and an in-order FIFO of
// outstanding loads, producing hold/bubble controls, a structural stall and a stall counter.
module hazard_scoreboard #(
    parameter int unsigned RAW     = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = 16
) (
    input logic               clk,
    input logic               rst_n,
    hazard_scoreboard_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [RAW-1:0]   entries_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_q;

    logic             full, empty, do_push, do_pop;
    logic [DEPTH-1:0] occupied;
    logic [PW-1:0]    off;
    logic [RAW-1:0]   src;
    logic             ex_ld, data_hz, struct_hz, pc_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign ex_ld = bus.ex_valid & bus.ex_mem_ren;

    // A full FIFO may still accept a push when the oldest entry retires in the same cycle.
    assign do_pop  = bus.ld_resp & ~empty;
    assign do_push = bus.ld_issue & (~full | bus.ld_resp);
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);
    assign err_d   = err_q | (bus.ld_issue & full & ~bus.ld_resp) | (bus.ld_resp & empty);

    always_comb begin
        occupied = '0;
        off      = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            off         = PW'(k) - rd_ptr_q;
            occupied[k] = ({1'b0, off} < count_q);
        end
    end

    always_comb begin
        data_hz = 1'b0;
        src     = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            src = bus.id_src_addr[i*RAW +: RAW];
            if (bus.id_src_valid[i] && src != '0) begin
                if (ex_ld && src == bus.ex_waddr) data_hz = 1'b1;
                for (int k = 0; k < int'(DEPTH); k++) begin
                    if (occupied[k] && entries_q[k] == src) data_hz = 1'b1;
                end
            end
        end
    end

    assign struct_hz = ex_ld & full & ~bus.ld_resp;
    assign pc_en     = ~(struct_hz | data_hz);

    assign bus.pc_enable         = pc_en;
    assign bus.if_id_enable      = pc_en;
    assign bus.id_ex_enable      = ~struct_hz;
    assign bus.hazard_clear_ctrl = ~struct_hz & data_hz;
    assign bus.sb_count          = count_q;
    assign bus.sb_err            = err_q;
    assign bus.stall_cycles      = stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(DEPTH); k++) entries_q[k] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            stall_q  <= '0;
        end else begin
            if (do_push) begin
                entries_q[wr_ptr_q] <= bus.ld_issue_waddr;
                wr_ptr_q            <= wr_ptr_q + PW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            err_q   <= err_d;
            if (!pc_en && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised + directed bench for hazard_scoreboard: a queue-based reference model predicts
// every cycle's outputs, a negedge monitor pops and compares them.
module tb_hazard_scoreboard;
    localparam int RAW   = 5;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.RAW(RAW), .NUM_SRC(2), .DEPTH(DEPTH), .CNT_W(16)) bus ();
    hazard_scoreboard_if #(.RAW(RAW), .NUM_SRC(2), .DEPTH(DEPTH), .CNT_W(4))  bus_sat ();

    assign bus_sat.id_src_valid   = bus.id_src_valid;
    assign bus_sat.id_src_addr    = bus.id_src_addr;
    assign bus_sat.ex_valid       = bus.ex_valid;
    assign bus_sat.ex_mem_ren     = bus.ex_mem_ren;
    assign bus_sat.ex_waddr       = bus.ex_waddr;
    assign bus_sat.ld_issue       = bus.ld_issue;
    assign bus_sat.ld_issue_waddr = bus.ld_issue_waddr;
    assign bus_sat.ld_resp        = bus.ld_resp;

    hazard_scoreboard #(.RAW(RAW), .NUM_SRC(2), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    hazard_scoreboard #(.RAW(RAW), .NUM_SRC(2), .DEPTH(DEPTH), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_sat)
    );

    typedef struct {
        bit pc, ifid, idex, clr, err;
        int cnt, st, st4;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned sbq[$];
    bit          m_err;
    int          m_st, m_st4;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_enable", int'(bus.pc_enable), int'(e.pc));
                chk("if_id_enable", int'(bus.if_id_enable), int'(e.ifid));
                chk("id_ex_enable", int'(bus.id_ex_enable), int'(e.idex));
                chk("hazard_clear_ctrl", int'(bus.hazard_clear_ctrl), int'(e.clr));
                chk("sb_count", int'(bus.sb_count), e.cnt);
                chk("sb_err", int'(bus.sb_err), int'(e.err));
                chk("stall_cycles", int'(bus.stall_cycles), e.st);
                chk("stall_cycles_w4", int'(bus_sat.stall_cycles), e.st4);
            end
        end
    end

    // Predict this cycle's outputs from the drive values, then advance the model past the edge.
    task automatic predict(input bit [1:0] sv, input int a0, input int a1, input bit exv,
                           input bit exr, input int exw, input bit iss, input int iw,
                           input bit resp, input bit advance);
        exp_t e;
        bit   dh = 0;
        bit   sh;
        int   a, sz;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? a0 : a1;
            if (sv[i] && a != 0) begin
                if (exv && exr && a == exw) dh = 1;
                foreach (sbq[k]) if (sbq[k] == a) dh = 1;
            end
        end
        sh     = exv && exr && sbq.size() == DEPTH && !resp;
        e.pc   = !(sh || dh);
        e.ifid = e.pc;
        e.idex = !sh;
        e.clr  = !sh && dh;
        e.cnt  = sbq.size();
        e.err  = m_err;
        e.st   = m_st;
        e.st4  = m_st4;
        exp_q.push_back(e);
        if (advance) begin
            if (!e.pc) begin
                if (m_st < 65535) m_st++;
                if (m_st4 < 15) m_st4++;
            end
            sz = sbq.size();
            if (resp) begin
                if (sz == 0) m_err = 1;
                else void'(sbq.pop_front());
            end
            if (iss) begin
                if (sz == DEPTH && !resp) m_err = 1;
                else sbq.push_back(iw);
            end
        end
    endtask

    task automatic drive(input bit [1:0] sv, input int a0, input int a1, input bit exv,
                         input bit exr, input int exw, input bit iss, input int iw,
                         input bit resp);
        bus.id_src_valid   = sv;
        bus.id_src_addr    = {RAW'(a1), RAW'(a0)};
        bus.ex_valid       = exv;
        bus.ex_mem_ren     = exr;
        bus.ex_waddr       = RAW'(exw);
        bus.ld_issue       = iss;
        bus.ld_issue_waddr = RAW'(iw);
        bus.ld_resp        = resp;
    endtask

    task automatic step(input bit [1:0] sv, input int a0, input int a1, input bit exv,
                        input bit exr, input int exw, input bit iss, input int iw,
                        input bit resp);
        @(posedge clk);
        #1;
        drive(sv, a0, a1, exv, exr, exw, iss, iw, resp);
        predict(sv, a0, a1, exv, exr, exw, iss, iw, resp, 1'b1);
    endtask

    // Asynchronous reset asserted mid-cycle; checked before the next clock edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        m_err = 0;
        m_st  = 0;
        m_st4 = 0;
        predict(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // EX load-use and its non-hazard variants
        step(2'b01, 5, 0, 1, 1, 5, 0, 0, 0);
        step(2'b00, 5, 0, 1, 1, 5, 0, 0, 0);
        step(2'b01, 0, 0, 1, 1, 0, 0, 0, 0);

        // Outstanding load: covered in issue cycle by EX, then by the scoreboard
        step(2'b10, 0, 7, 1, 1, 7, 1, 7, 0);
        repeat (3) step(2'b10, 0, 7, 0, 0, 0, 0, 0, 0);
        step(2'b10, 0, 7, 0, 0, 0, 0, 0, 1);
        step(2'b10, 0, 7, 0, 0, 0, 0, 0, 0);

        // Full scoreboard: structural stall, then suppressed by a same-cycle response
        for (int i = 1; i <= 4; i++) step(2'b00, 0, 0, 0, 0, 0, 1, i, 0);
        step(2'b00, 0, 0, 1, 1, 9, 0, 0, 0);
        step(2'b00, 0, 0, 1, 1, 9, 1, 9, 1);
        step(2'b01, 9, 0, 0, 0, 0, 0, 0, 0);
        // 5th issue at full without a response
        step(2'b00, 0, 0, 0, 0, 0, 1, 10, 0);
        repeat (2) step(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Response while empty, with and without a simultaneous issue
        step(2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
        step(2'b00, 0, 0, 0, 0, 0, 1, 6, 1);
        step(2'b01, 6, 0, 0, 0, 0, 0, 0, 1);
        step(2'b01, 6, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // 12 issue/response pairs across pointer wrap
        for (int i = 0; i < 12; i++) begin
            step(2'b00, 0, 0, 0, 0, 0, 1, (i % 7) + 1, 0);
            step(2'b11, (i % 7) + 1, ((i + 1) % 7) + 1, 0, 0, 0, 0, 0, 1);
        end

        // Continuous stall long enough to saturate the 4-bit counter
        repeat (20) step(2'b01, 3, 0, 1, 1, 3, 0, 0, 0);
        do_reset();

        for (int n = 0; n < 600; n++) begin
            if (n % 200 == 199) do_reset();
            else step(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                      $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
                      $urandom_range(0, 2) == 0);
        end

        @(posedge clk);
        #1;
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) chk("monitor_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised load-use hazard unit for the NPC pipeline, replacing the single-stage load-use comparator. It compares the decode-stage source registers against the load in EX and against every load outstanding in a multi-cycle memory, tracked by an in-order scoreboard FIFO. It drives the PC/IF-ID hold and ID/EX bubble controls, adds a structural stall when the scoreboard is full, ignores x0, and counts stall cycles for performance analysis.

## Interface
- RAW, default 5: register address width (matches `REG_ADDR_WIDTH`).
- NUM_SRC, default 2: number of decode-stage source operands compared.
- DEPTH, default 4: maximum outstanding loads; power of two, ≥2.
- CNT_W, default 16: stall counter width.

- clk, input, 1: sole clock; all state on rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- id_src_valid, input, NUM_SRC: per-operand "operand is read" flag.
- id_src_addr, input, NUM_SRC*RAW: packed source addresses; operand i is at [i*RAW +: RAW].
- ex_valid, input, 1: EX stage holds a live instruction.
- ex_mem_ren, input, 1: EX instruction is a load.
- ex_waddr, input, RAW: EX destination register.
- ld_issue, input, 1: pulse; a load leaves EX into memory this cycle.
- ld_issue_waddr, input, RAW: destination of the issued load.
- ld_resp, input, 1: pulse; the oldest outstanding load writes back this cycle.
- pc_enable, output, 1: 0 holds the PC.
- if_id_enable, output, 1: 0 holds the IF/ID register.
- id_ex_enable, output, 1: 0 holds ID/EX (structural stall only).
- hazard_clear_ctrl, output, 1: 1 inserts a bubble into ID/EX.
- sb_count, output, $clog2(DEPTH)+1: outstanding load count.
- stall_cycles, output, CNT_W: saturating count of cycles with pc_enable=0.
- sb_err, output, 1: sticky overflow/underflow flag.

## Operation
- Scoreboard: circular FIFO of DEPTH RAW-bit entries, with wr_ptr, rd_ptr and count.
  - ld_issue pushes ld_issue_waddr.
  - ld_resp pops the oldest entry.
  - Both in one cycle: push and pop together, count unchanged. This is legal even when full.
  - Pointers wrap modulo DEPTH.
- Pending match: operand i matches when all of these hold:
  - id_src_valid[i]=1;
  - its address ≠ 0;
  - it equals ex_waddr with ex_valid&ex_mem_ren, or it equals any occupied scoreboard entry.
- Unoccupied entries never match. An entry being popped this cycle still matches; it is released the following cycle.
- data_hz = OR of the pending matches. Loads with ex_waddr=0 never cause data_hz.
- struct_hz = ex_valid & ex_mem_ren & (count==DEPTH) & ~ld_resp.
- Outputs (combinational from current state and inputs):
  - struct_hz=1: pc_enable=0, if_id_enable=0, id_ex_enable=0, hazard_clear_ctrl=0. This freezes the pipeline and takes priority over data_hz.
  - Else data_hz=1: pc_enable=0, if_id_enable=0, id_ex_enable=1, hazard_clear_ctrl=1.
  - Else: pc_enable=1, if_id_enable=1, id_ex_enable=1, hazard_clear_ctrl=0.
- Error handling (sb_err set, sticks until reset):
  - ld_issue while full without ld_resp: push dropped.
  - ld_resp while empty: pop ignored; a simultaneous issue still pushes.
- stall_cycles increments every cycle with pc_enable=0 and saturates at all-ones.

## Timing
- Reset (rst_n=0, async):
  - count=0, pointers=0, entries=0, sb_err=0, stall_cycles=0.
  - With no hazard inputs: pc_enable=1, if_id_enable=1, id_ex_enable=1, hazard_clear_ctrl=0, sb_count=0.
  - Reset mid-stall discards all outstanding entries immediately.
- Hazard outputs are combinational, zero latency.
- Scoreboard updates become visible the cycle after ld_issue or ld_resp.
- An issued load is covered in its issue cycle by the EX comparison, then by the scoreboard from the next cycle, with no gap.
- sb_count, sb_err and stall_cycles are registered and update one cycle after the triggering condition.

## Test plan
- Reset: drive rst_n=0 asynchronously mid-cycle -> all outputs at reset values immediately; sb_count=0, stall_cycles=0.
- EX load-use: ex_valid=1, ex_mem_ren=1, ex_waddr=5, src0=5 valid -> pc_enable=0, if_id_enable=0, hazard_clear_ctrl=1. Repeat with src0=5 invalid, or with ex_waddr=0 and src0=0 -> no stall.
- Outstanding load:
  - ld_issue with waddr=7, then src1=7 on the next cycle -> stall each cycle until ld_resp.
  - Stall is still asserted in the ld_resp cycle and deasserted the cycle after.
  - sb_count goes 1 -> 0.
- Full scoreboard: issue 4 loads (DEPTH=4), then present an EX load -> id_ex_enable=0, hazard_clear_ctrl=0. The same cycle with ld_resp=1 -> no structural stall, and sb_count stays 4.
- Errors:
  - ld_resp at count=0 -> sb_err=1 next cycle, count stays 0.
  - 5th ld_issue at full without ld_resp -> sb_err=1, sb_count stays 4.
- Counter and wrap: run 12 issue/response pairs across pointer wrap-around -> matches stay correct. Force a continuous stall with CNT_W=4 -> stall_cycles saturates at 15.
